// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: a circular buffer of dispatched load/store ops that
// tracks per-source readiness from the wakeup buses and issues the head op when it is ready.
module mem_issue_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned ROB_W     = 6,
   parameter int unsigned PREG_W    = 7,
   parameter int unsigned PAYLOAD_W = 64,
   parameter int unsigned WAKE_N    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       dis_valid_i,
   output logic                       dis_ready_o,
   input  logic [ROB_W-1:0]           dis_rob_idx_i,
   input  logic [PREG_W-1:0]          dis_psrc0_i,
   input  logic [PREG_W-1:0]          dis_psrc1_i,
   input  logic                       dis_src0_rdy_i,
   input  logic                       dis_src1_rdy_i,
   input  logic [PAYLOAD_W-1:0]       dis_payload_i,
   input  logic [WAKE_N-1:0]          wk_valid_i,
   input  logic [WAKE_N*PREG_W-1:0]   wk_preg_i,
   output logic                       iss_valid_o,
   input  logic                       iss_ready_i,
   output logic [ROB_W-1:0]           iss_rob_idx_o,
   output logic [PREG_W-1:0]          iss_psrc0_o,
   output logic [PREG_W-1:0]          iss_psrc1_o,
   output logic [PAYLOAD_W-1:0]       iss_payload_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [ROB_W-1:0]     r_rob     [DEPTH];
   logic [PREG_W-1:0]    r_psrc0   [DEPTH];
   logic [PREG_W-1:0]    r_psrc1   [DEPTH];
   logic [PAYLOAD_W-1:0] r_payload [DEPTH];
   logic [DEPTH-1:0]     r_rdy0;
   logic [DEPTH-1:0]     r_rdy1;

   logic [IDX_W-1:0]     w_hidx;
   logic [IDX_W-1:0]     w_tidx;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_dis_fire;
   logic                 w_iss_fire;
   logic                 w_dis_rdy0;
   logic                 w_dis_rdy1;

   // True when any valid wakeup port names this physical register.
   function automatic logic f_wake(input logic [PREG_W-1:0] p);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < WAKE_N; k++) begin
         if (wk_valid_i[k] && (wk_preg_i[k*PREG_W +: PREG_W] == p)) hit = 1'b1;
      end
      return hit;
   endfunction

   assign w_hidx      = r_head[IDX_W-1:0];
   assign w_tidx      = r_tail[IDX_W-1:0];
   assign w_empty     = (r_head == r_tail);
   assign w_full      = (w_hidx == w_tidx) && (r_head[IDX_W] != r_tail[IDX_W]);
   assign dis_ready_o = ~w_full;
   assign iss_valid_o = ~w_empty & r_rdy0[w_hidx] & r_rdy1[w_hidx] & ~flush_i;
   assign w_dis_fire  = dis_valid_i & ~w_full & ~flush_i;
   assign w_iss_fire  = iss_valid_o & iss_ready_i;
   assign count_o     = r_tail - r_head;

   assign w_dis_rdy0  = dis_src0_rdy_i | (dis_psrc0_i == '0) | f_wake(dis_psrc0_i);
   assign w_dis_rdy1  = dis_src1_rdy_i | (dis_psrc1_i == '0) | f_wake(dis_psrc1_i);

   assign iss_rob_idx_o = r_rob[w_hidx];
   assign iss_psrc0_o   = r_psrc0[w_hidx];
   assign iss_psrc1_o   = r_psrc1[w_hidx];
   assign iss_payload_o = r_payload[w_hidx];

   // Pointers; flush wins over any same-cycle dispatch or issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (flush_i) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_dis_fire) r_tail <= r_tail + PTR_W'(1);
         if (w_iss_fire) r_head <= r_head + PTR_W'(1);
      end
   end

   // Ready bits: loaded at allocation (including same-cycle wakeup), then sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy0 <= '0;
         r_rdy1 <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_dis_fire && (w_tidx == IDX_W'(i))) begin
               r_rdy0[i] <= w_dis_rdy0;
               r_rdy1[i] <= w_dis_rdy1;
            end else begin
               if (f_wake(r_psrc0[i])) r_rdy0[i] <= 1'b1;
               if (f_wake(r_psrc1[i])) r_rdy1[i] <= 1'b1;
            end
         end
      end
   end

   // Entry data is written on dispatch and never cleared.
   always_ff @(posedge clk) begin
      if (w_dis_fire) begin
         r_rob[w_tidx]     <= dis_rob_idx_i;
         r_psrc0[w_tidx]   <= dis_psrc0_i;
         r_psrc1[w_tidx]   <= dis_psrc1_i;
         r_payload[w_tidx] <= dis_payload_i;
      end
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed scoreboard bench for mem_issue_queue: accepted dispatches are queued
// and compared in order against every observed issue handshake.
module tb_mem_issue_queue;

   localparam int unsigned DEPTH = 8;

   logic          clk;
   logic          rst_n;
   logic          flush_i;
   logic          dis_valid_i;
   logic          dis_ready_o;
   logic [5:0]    dis_rob_idx_i;
   logic [6:0]    dis_psrc0_i;
   logic [6:0]    dis_psrc1_i;
   logic          dis_src0_rdy_i;
   logic          dis_src1_rdy_i;
   logic [63:0]   dis_payload_i;
   logic [1:0]    wk_valid_i;
   logic [13:0]   wk_preg_i;
   logic          iss_valid_o;
   logic          iss_ready_i;
   logic [5:0]    iss_rob_idx_o;
   logic [6:0]    iss_psrc0_o;
   logic [6:0]    iss_psrc1_o;
   logic [63:0]   iss_payload_o;
   logic [3:0]    count_o;

   typedef struct packed {
      logic [5:0]  rob;
      logic [6:0]  p0;
      logic [6:0]  p1;
      logic [63:0] pl;
   } ent_t;

   ent_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_cnt   = 0;

   mem_issue_queue #(.DEPTH(DEPTH), .ROB_W(6), .PREG_W(7), .PAYLOAD_W(64), .WAKE_N(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .dis_valid_i(dis_valid_i), .dis_ready_o(dis_ready_o),
      .dis_rob_idx_i(dis_rob_idx_i), .dis_psrc0_i(dis_psrc0_i), .dis_psrc1_i(dis_psrc1_i),
      .dis_src0_rdy_i(dis_src0_rdy_i), .dis_src1_rdy_i(dis_src1_rdy_i),
      .dis_payload_i(dis_payload_i),
      .wk_valid_i(wk_valid_i), .wk_preg_i(wk_preg_i),
      .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
      .iss_rob_idx_o(iss_rob_idx_o), .iss_psrc0_o(iss_psrc0_o), .iss_psrc1_o(iss_psrc1_o),
      .iss_payload_o(iss_payload_o), .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic dis(input int rob, input int p0, input int p1, input bit r0, input bit r1);
      dis_valid_i    = 1'b1;
      dis_rob_idx_i  = 6'(rob);
      dis_psrc0_i    = 7'(p0);
      dis_psrc1_i    = 7'(p1);
      dis_src0_rdy_i = r0;
      dis_src1_rdy_i = r1;
      dis_payload_i  = {$urandom, $urandom};
   endtask

   // One cycle: check outputs at negedge, score handshakes, advance the occupancy model.
   task automatic tick(input int ev);
      ent_t e;
      bit   acc;
      bit   iss;
      @(negedge clk);
      if (ev != 2) chk("iss_valid", 64'(iss_valid_o), 64'(ev));
      acc = dis_valid_i && !flush_i && (m_cnt < DEPTH);
      iss = iss_valid_o && iss_ready_i;
      if (iss) begin
         if (sb.size() == 0) chk("issue_expected", 64'(sb.size()), 64'd1);
         else begin
            e = sb.pop_front();
            chk("iss_rob", 64'(iss_rob_idx_o), 64'(e.rob));
            chk("iss_psrc0", 64'(iss_psrc0_o), 64'(e.p0));
            chk("iss_psrc1", 64'(iss_psrc1_o), 64'(e.p1));
            chk("iss_payload", iss_payload_o, e.pl);
         end
      end
      if (acc) sb.push_back({dis_rob_idx_i, dis_psrc0_i, dis_psrc1_i, dis_payload_i});
      @(posedge clk);
      #1;
      if (flush_i) begin
         m_cnt = 0;
         sb.delete();
      end else begin
         m_cnt = m_cnt + int'(acc) - int'(iss);
      end
      dis_valid_i = 1'b0;
      wk_valid_i  = '0;
      flush_i     = 1'b0;
      #1;
      chk("count", 64'(count_o), 64'(m_cnt));
      chk("dis_ready", 64'(dis_ready_o), 64'(m_cnt < DEPTH));
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; dis_valid_i = 1'b0; iss_ready_i = 1'b0;
      dis_rob_idx_i = '0; dis_psrc0_i = '0; dis_psrc1_i = '0;
      dis_src0_rdy_i = 1'b0; dis_src1_rdy_i = 1'b0; dis_payload_i = '0;
      wk_valid_i = '0; wk_preg_i = '0;
      #2;
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_iss_valid", 64'(iss_valid_o), 64'd0);
      chk("rst_dis_ready", 64'(dis_ready_o), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic flow
      iss_ready_i = 1'b1;
      dis(3, 1, 2, 1, 1); tick(0);
      dis(4, 5, 6, 1, 1); tick(1);
      tick(1);
      tick(0);

      // In-order blocking behind a not-ready head, released by port-1 wakeup
      dis(5, 12, 0, 0, 0); tick(0);
      dis(6, 3, 4, 1, 1);  tick(0);
      tick(0);
      wk_valid_i = 2'b10; wk_preg_i = {7'd12, 7'd0}; tick(0);
      tick(1);
      tick(1);
      tick(0);

      // Same-cycle wakeup on port 0 during dispatch
      dis(7, 9, 20, 1, 0); wk_valid_i = 2'b01; wk_preg_i = {7'd0, 7'd20}; tick(0);
      tick(1);
      tick(0);

      // Fill to full, try an extra dispatch, then drain across the wrap
      iss_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dis(i, i + 1, 0, 1, 1); tick(i == 0 ? 0 : 1);
      end
      chk("full_count", 64'(count_o), 64'd8);
      chk("full_dis_ready", 64'(dis_ready_o), 64'd0);
      dis(50, 1, 1, 1, 1); tick(1);
      iss_ready_i = 1'b1;
      tick(1);
      for (int i = 8; i < 12; i++) begin
         dis(i, i + 1, 0, 1, 1); tick(1);
      end
      for (int i = 0; i < 7; i++) tick(1);
      tick(0);
      chk("wrap_sb_drained", 64'(sb.size()), 64'd0);

      // Backpressure: head held stable for 3 cycles, then one issue
      iss_ready_i = 1'b0;
      dis(20, 33, 34, 1, 1); tick(0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("bp_rob", 64'(iss_rob_idx_o), 64'(sb[0].rob));
         chk("bp_payload", iss_payload_o, sb[0].pl);
      end
      iss_ready_i = 1'b1;
      tick(1);
      tick(0);

      // Flush with 5 queued, concurrent dispatch and ready
      iss_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dis(30 + i, 0, 0, 1, 1); tick(i == 0 ? 0 : 1);
      end
      iss_ready_i = 1'b1; flush_i = 1'b1;
      dis(40, 0, 0, 1, 1); tick(0);
      chk("flush_count", 64'(count_o), 64'd0);
      dis(41, 2, 3, 1, 1); tick(0);
      tick(1);
      tick(0);

      // Asynchronous reset mid-operation
      iss_ready_i = 1'b0;
      dis(42, 0, 0, 1, 1); tick(0);
      dis(43, 0, 0, 1, 1); tick(1);
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count_o), 64'd0);
      chk("arst_iss_valid", 64'(iss_valid_o), 64'd0);
      chk("arst_dis_ready", 64'(dis_ready_o), 64'd1);
      m_cnt = 0; sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      iss_ready_i = 1'b1;
      dis(44, 0, 0, 1, 1); tick(0);
      tick(1);
      tick(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for the memory pipeline, sitting between dispatch/rename and the memory execute block. It buffers dispatched load/store micro-ops and tracks operand readiness from the physical-register wakeup buses. It issues micro-ops strictly in program order, one per cycle, through a valid/ready handshake into the memory stage register. Any pipeline flush empties it.

## Interface
- DEPTH, 8, entry count; power of two, ≥2
- ROB_W, 6, ROB index width
- PREG_W, 7, physical register index width
- PAYLOAD_W, 64, opaque micro-op payload (imm, mem opcode, align, pdest); carried unmodified
- WAKE_N, 2, number of wakeup ports
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush; discards all entries
- dis_valid_i  in  1  dispatch request
- dis_ready_o  out  1  queue can accept (= not full)
- dis_rob_idx_i  in  ROB_W  ROB index of dispatched op
- dis_psrc0_i / dis_psrc1_i  in  PREG_W each  source physical registers
- dis_src0_rdy_i / dis_src1_rdy_i  in  1 each  source already available at dispatch
- dis_payload_i  in  PAYLOAD_W  micro-op payload
- wk_valid_i  in  WAKE_N  wakeup strobes
- wk_preg_i  in  WAKE_N*PREG_W  woken physical registers, port k at bits [k*PREG_W +: PREG_W]
- iss_valid_o  out  1  head entry issuable
- iss_ready_i  in  1  memory stage accepts
- iss_rob_idx_o, iss_psrc0_o, iss_psrc1_o, iss_payload_o  out  as dispatch  head entry fields
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer. head/tail pointers are $clog2(DEPTH)+1 bits, including a wrap bit.
  - empty: head==tail.
  - full: index bits are equal and the wrap bits differ.
- Dispatch: on dis_valid_i & dis_ready_o & ~flush_i, write the entry at tail and increment tail.
- Issue: on iss_valid_o & iss_ready_i, increment head. The entry's payload is not cleared.
- Ready bits per source, rdy = 1 when any of the following holds:
  - the matching dis_srcN_rdy_i is set;
  - psrc == 0 (the zero register is always ready);
  - some wakeup port k has wk_valid_i[k] and wk_preg_i[k] == psrc.
- Wakeup sources:
  - Same-cycle wakeup is honoured for an entry being written this cycle.
  - Every cycle, all valid entries OR in wakeup matches. Set bits never clear until the entry is reallocated.
- iss_valid_o = ~empty & head.rdy0 & head.rdy1 & ~flush_i.
  - A blocked head blocks all younger entries; there is no out-of-order issue.
- iss_* data outputs are combinational from the head entry and are stable while iss_valid_o & ~iss_ready_i.
- dis_ready_o = ~full. It does not depend on same-cycle issue, so there is no combinational dis↔iss path.
- Flush: head, tail and count go to 0 on the next edge. Same-cycle dispatch is dropped and same-cycle issue is suppressed.
- count_o = tail − head (modular, full width).
  - Simultaneous dispatch and issue leaves count unchanged and advances both pointers.

## Timing
- Reset values:
  - head = tail = 0 and count_o = 0.
  - iss_valid_o = 0 and dis_ready_o = 1.
  - All entry ready bits = 0.
  - iss data outputs = entry 0 contents (don't-care).
- Issue latency:
  - An op dispatched with both sources ready into an empty queue in cycle N shows iss_valid_o in cycle N+1.
  - A wakeup in cycle N for the head makes iss_valid_o rise in N+1.
- Throughput: one issue per cycle when the head is continuously ready.
- Full: dis_ready_o drops in the cycle after the DEPTH-th write. It rises the cycle after the first issue from full.
- Pointer wrap: index wraps DEPTH−1 → 0 and toggles the wrap bit. No entry is lost or duplicated across the wrap.
- Reset asserted mid-operation clears state asynchronously. Outputs take their reset values immediately.

## Test plan
- Basic flow:
  - Stimulus: dispatch rob 3 (both rdy) then rob 4 (both rdy); iss_ready_i = 1.
  - Required: iss_valid_o in cycles 1 and 2 with iss_rob_idx_o 3 then 4; count_o returns to 0.
- In-order blocking:
  - Stimulus: rob 5 with psrc0 = 12 not ready, then rob 6 fully ready.
  - Required: no issue.
  - Stimulus: wk_valid_i[1] = 1 with wk_preg_i port1 = 12.
  - Required: next cycle issues 5, following cycle issues 6.
- Same-cycle wakeup:
  - Stimulus: dispatch psrc1 = 20 not ready while wk_preg_i port0 = 20 is valid in the same cycle.
  - Required: entry issues the next cycle.
- Full and wrap:
  - Stimulus: iss_ready_i = 0; dispatch 8 ready ops.
  - Required: dis_ready_o = 0 and count_o = 8.
  - Stimulus: release ready; dispatch 4 more.
  - Required: order rob 0..11 preserved across pointer wrap.
- Backpressure:
  - Stimulus: hold iss_ready_i = 0 for 3 cycles with a valid head.
  - Required: iss_* stable throughout; a single issue on release.
- Flush:
  - Stimulus: 5 entries queued; assert flush_i together with dis_valid_i and iss_ready_i.
  - Required: iss_valid_o = 0 that cycle, no dispatch accepted, count_o = 0 next cycle, and a new dispatch then issues normally.
